bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Two-master round-robin arbiter for the MCU data bus (busWe/busAddr/busWData/busFunc3/busRData).
//   Shares the single RAM port between the CPU_RV32I load/store path (m0) and a second master (m1, e.g. DMA).
//   Registered 3-state sequencer: arbitrate/latch command, drive RAM for one cycle, return read data with a done pulse.
// PARAMETERS
//   ADDR_W    32  address width of masters and bus
//   DATA_W    32  data width of masters and bus
//   LOCK_MAX  4   max consecutive locked grants to one master (only with BUS_ARB_LOCK_EN)
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst        in   1       asynchronous reset, ACTIVE-LOW
//   m0_req     in   1       m0 request; command must be stable while req=1 and gnt0=0
//   m0_we      in   1       m0 write(1)/read(0)
//   m0_addr    in   ADDR_W  m0 byte address
//   m0_wdata   in   DATA_W  m0 write data
//   m0_func3   in   3       m0 access size code (passed to busFunc3)
//   m0_lock    in   1       m0 lock request (used only with BUS_ARB_LOCK_EN)
//   m0_gnt     out  1       m0 command accepted this cycle (combinational, IDLE only)
//   m0_done    out  1       one-cycle pulse: m0 transfer complete, rdata valid
//   m1_*       -    -       identical set for m1 (req, we, addr, wdata, func3, lock, gnt, done)
//   rdata      out  DATA_W  registered read data of last completed read
//   busWe      out  1       RAM write enable
//   busAddr    out  ADDR_W  RAM address
//   busWData   out  DATA_W  RAM write data
//   busFunc3   out  3       RAM access size
//   busRData   in   DATA_W  RAM combinational read data
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, last=1 (m0 wins first tie), lock_cnt=0; all outputs 0.
//   Reset mid-transfer: busWe drops immediately, no done pulse; write in flight is not committed.
//   States:
//     IDLE    If any req: pick winner, assert its gnt (combinational), latch we/addr/wdata/func3 and id.
//             Next state ACCESS. With no req, remain in IDLE.
//     ACCESS  bus* driven from latched command; busWe=latched we. RAM write commits at this edge.
//             If read, rdata<=busRData at this edge. Next state RESP.
//     RESP    bus* return to 0; done of latched id =1 for exactly one cycle. Next state IDLE.
//   Timing: gnt in cycle N -> busWe/addr valid cycle N+1 -> done and rdata valid cycle N+2.
//   Each transfer occupies 3 cycles; the next grant is possible at N+3.
//   Arbitration: single req wins outright. On a tie, the winner is the master not equal to last.
//     last is updated at every grant.
//   rdata holds its value until the next completed read; writes do not change it.
//   gnt and done are never asserted to both masters in the same cycle.
//   busAddr/busWData/busFunc3 are 0 outside ACCESS, so the RAM sees no spurious write.
//   Widths: addr, data and func3 pass through unmodified; no address decode in this block.
// CONFIGURATION
//   BUS_ARB_LOCK_EN defined:
//     Suppose the granted master had lock=1 at grant and lock_cnt<LOCK_MAX, and it requests again in IDLE.
//     Then it is regranted regardless of round-robin order, and lock_cnt is incremented.
//     lock_cnt clears when any grant is made with lock=0, or when a grant goes to the other master.
//     Once lock_cnt reaches LOCK_MAX, normal round-robin applies for that grant.
//   BUS_ARB_LOCK_EN undefined: m*_lock ignored, pure round-robin, lock_cnt not built.
// TESTING
//   1. m0 write addr=0x10 wdata=0xDEADBEEF func3=3'b010.
//      -> m0_gnt cycle N; busWe=1, busAddr=0x10 in cycle N+1; m0_done in cycle N+2.
//      Then m0 read 0x10 -> rdata=0xDEADBEEF at done.
//   2. After reset, m0_req and m1_req asserted together, each for one transfer.
//      -> m0 granted cycle N, m1 granted cycle N+3; done0 at N+2, done1 at N+5.
//   3. Both reqs held high for 4 transfers -> grant order 0,1,0,1; no cycle with both gnt or both done.
//   4. Assert rst=0 during ACCESS of an m1 write.
//      -> busWe=0 immediately; no m1_done; RAM word unchanged.
//      After release, a tie grants m0 first.
//   5. BUS_ARB_LOCK_EN, LOCK_MAX=2; m1 lock=1 and m0 requesting continuously.
//      -> grants 1,1,1,0 (initial grant plus 2 locked regrants).
//      Without the macro -> 1,0,1,0.
//   6. m1 read 0x20 (=0x12345678), then m0 write 0x24 -> rdata stays 0x12345678 through m0_done.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Two-master data-bus bundle: master request/grant/done lines,
// shared read data and the single RAM port.
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [2:0]        m0_func3;
    logic              m0_lock;
    logic              m0_gnt;
    logic              m0_done;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [2:0]        m1_func3;
    logic              m1_lock;
    logic              m1_gnt;
    logic              m1_done;

    logic [DATA_W-1:0] rdata;

    logic              busWe;
    logic [ADDR_W-1:0] busAddr;
    logic [DATA_W-1:0] busWData;
    logic [2:0]        busFunc3;
    logic [DATA_W-1:0] busRData;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_func3, m0_lock,
        output m0_gnt, m0_done,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_func3, m1_lock,
        output m1_gnt, m1_done,
        output rdata,
        output busWe, busAddr, busWData, busFunc3,
        input  busRData
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_func3, m0_lock,
        input  m0_gnt, m0_done,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_func3, m1_lock,
        input  m1_gnt, m1_done,
        input  rdata,
        input  busWe, busAddr, busWData, busFunc3,
        output busRData
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin RAM port arbiter, IDLE/ACCESS/RESP sequencer.
// Optional grant locking is built when BUS_ARB_LOCK_EN is defined.
module bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_func3;
    logic [DATA_W-1:0] r_rdata;

    logic              w_any;
    logic              w_win;
    logic              w_grant;
    logic              w_access;
    logic              w_resp;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [2:0]        w_func3;

`ifdef BUS_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0]     r_lock_cnt;
    logic              r_lock_flag;
    logic              w_relock;
    logic              w_lock;
`else
    logic              w_unused_lock;
    assign w_unused_lock = bus.m0_lock ^ bus.m1_lock;
`endif

    // Winner selection, next state and per-state strobes
    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_access = 1'b0;
        w_resp   = 1'b0;
        w_any    = bus.m0_req | bus.m1_req;
        if (bus.m0_req && !bus.m1_req) begin
            w_win = 1'b0;
        end else if (bus.m1_req && !bus.m0_req) begin
            w_win = 1'b1;
        end else begin
            w_win = ~r_last;
        end
`ifdef BUS_ARB_LOCK_EN
        w_relock = r_lock_flag
                 && (r_lock_cnt < CW'(LOCK_MAX))
                 && (r_last ? bus.m1_req : bus.m0_req);
        if (w_relock) begin
            w_win = r_last;
        end
        w_lock = w_win ? bus.m1_lock : bus.m0_lock;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant = 1'b1;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_access = 1'b1;
                w_next   = S_RESP;
            end
            S_RESP: begin
                w_resp = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command of the selected master
    always_comb begin
        w_we    = w_win ? bus.m1_we    : bus.m0_we;
        w_addr  = w_win ? bus.m1_addr  : bus.m0_addr;
        w_wdata = w_win ? bus.m1_wdata : bus.m0_wdata;
        w_func3 = w_win ? bus.m1_func3 : bus.m0_func3;
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch granted command and capture read data in ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_func3 <= '0;
            r_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_last  <= w_win;
                r_id    <= w_win;
                r_we    <= w_we;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_func3 <= w_func3;
            end
            if (w_access && !r_we) begin
                r_rdata <= bus.busRData;
            end
        end
    end

`ifdef BUS_ARB_LOCK_EN
    // Lock run length: bump on locked regrant, clear on unlocked or switch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_cnt  <= '0;
            r_lock_flag <= 1'b0;
        end else if (w_grant) begin
            r_lock_flag <= w_lock;
            if (w_relock) begin
                r_lock_cnt <= r_lock_cnt + CW'(1);
            end else if (!w_lock || (w_win != r_last)) begin
                r_lock_cnt <= '0;
            end
        end
    end
`endif

    assign bus.m0_gnt   = rst & w_grant & ~w_win;
    assign bus.m1_gnt   = rst & w_grant &  w_win;
    assign bus.m0_done  = w_resp & ~r_id;
    assign bus.m1_done  = w_resp &  r_id;
    assign bus.rdata    = r_rdata;
    assign bus.busWe    = w_access & r_we;
    assign bus.busAddr  = w_access ? r_addr  : '0;
    assign bus.busWData = w_access ? r_wdata : '0;
    assign bus.busFunc3 = w_access ? r_func3 : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: transaction-level reference model
// feeds expectation queues; an independent monitor checks DUT outputs.
module tb_bus_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LMAX = 2;

    typedef struct {
        int          cyc;
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rd;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    bus_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LOCK_MAX(LMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    logic [31:0] mem [0:15];
    assign bif.busRData = mem[bif.busAddr[5:2]];
    always @(posedge clk) begin
        if (bif.busWe) mem[bif.busAddr[5:2]] <= bif.busWData;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    txn_t gq[$];
    txn_t aq[$];
    txn_t dq[$];
    int   obs_q[$];

    logic        pend [2];
    logic        granted [2];
    logic        c_we [2];
    logic        c_lock [2];
    logic [31:0] c_addr [2];
    logic [31:0] c_wdata [2];
    logic [2:0]  c_f3 [2];
    bit          rnd = 0;
    bit          refill = 0;

    logic [31:0] ref_mem [0:15];
    logic [31:0] m_rdata = '0;
    int          m_last = 1;
    int          m_free = 0;
    int          gcount = 0;
    bit          lk_flag = 0;
    int          lk_cnt = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive();
        bif.m0_req   = pend[0];
        bif.m0_we    = c_we[0];
        bif.m0_addr  = c_addr[0];
        bif.m0_wdata = c_wdata[0];
        bif.m0_func3 = c_f3[0];
        bif.m0_lock  = c_lock[0];
        bif.m1_req   = pend[1];
        bif.m1_we    = c_we[1];
        bif.m1_addr  = c_addr[1];
        bif.m1_wdata = c_wdata[1];
        bif.m1_func3 = c_f3[1];
        bif.m1_lock  = c_lock[1];
    endtask

    // Transaction-level reference: one transfer per 3 cycles, round robin
    task automatic model();
        int   w;
        bit   relock;
        txn_t t;
        if (rst && cyc >= m_free && (pend[0] || pend[1])) begin
            if (pend[0] && !pend[1]) w = 0;
            else if (pend[1] && !pend[0]) w = 1;
            else w = 1 - m_last;
            relock = 0;
`ifdef BUS_ARB_LOCK_EN
            relock = lk_flag && lk_cnt < LMAX && pend[m_last];
            if (relock) w = m_last;
            if (relock) lk_cnt++;
            else if (!c_lock[w] || w != m_last) lk_cnt = 0;
            lk_flag = c_lock[w];
`endif
            if (c_we[w]) ref_mem[c_addr[w][5:2]] = c_wdata[w];
            else m_rdata = ref_mem[c_addr[w][5:2]];
            t.cyc   = cyc;
            t.id    = w;
            t.we    = c_we[w];
            t.addr  = c_addr[w];
            t.wdata = c_wdata[w];
            t.f3    = c_f3[w];
            t.rd    = m_rdata;
            gq.push_back(t);
            aq.push_back(t);
            dq.push_back(t);
            granted[w] = 1;
            m_last = w;
            m_free = cyc + 3;
            gcount++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (granted[i]) begin
                pend[i]    = 0;
                granted[i] = 0;
            end
            if (rnd && !pend[i] && $urandom_range(2) == 0) begin
                pend[i]    = 1;
                c_we[i]    = 1'($urandom_range(1));
                c_addr[i]  = 32'($urandom_range(15)) << 2;
                c_wdata[i] = $urandom;
                c_f3[i]    = 3'($urandom_range(7));
                c_lock[i]  = 1'($urandom_range(1));
            end
            if (refill && !pend[i]) begin
                pend[i]    = 1;
                c_we[i]    = 0;
                c_addr[i]  = 32'(i * 4);
                c_wdata[i] = 0;
                c_f3[i]    = 3'b010;
                c_lock[i]  = (i == 1);
            end
        end
        drive();
        model();
    endtask

    task automatic issue(int id, logic we, logic [31:0] a, logic [31:0] d,
                         logic [2:0] f3, logic lk);
        int k = 0;
        while (pend[id] && k < 200) begin
            step();
            k++;
        end
        c_we[id]    = we;
        c_addr[id]  = a;
        c_wdata[id] = d;
        c_f3[id]    = f3;
        c_lock[id]  = lk;
        pend[id]    = 1;
    endtask

    task automatic drain();
        int k = 0;
        while ((pend[0] || pend[1] || cyc < m_free) && k < 500) begin
            step();
            k++;
        end
        chk("drain_bound", 32'(k >= 500), 0);
    endtask

    task automatic model_reset();
        gq.delete();
        aq.delete();
        dq.delete();
        m_last  = 1;
        m_rdata = '0;
        lk_flag = 0;
        lk_cnt  = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i]    = 0;
            granted[i] = 0;
        end
    endtask

    task automatic release_rst();
        rst    = 1'b1;
        m_free = cyc;
        model();
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    initial forever begin
        txn_t t;
        int   id;
        @(negedge clk);
        #2;
        if (rst) begin
            chk("excl", {30'b0, bif.m0_gnt & bif.m1_gnt,
                         bif.m0_done & bif.m1_done}, 0);
            if (bif.m0_gnt || bif.m1_gnt) begin
                id = bif.m1_gnt ? 1 : 0;
                obs_q.push_back(id);
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 1, 0);
                end else begin
                    t = gq.pop_front();
                    chk("gnt_cycle", cyc, t.cyc);
                    chk("gnt_id", id, t.id);
                end
            end
            if (aq.size() != 0 && aq[0].cyc + 1 == cyc) begin
                t = aq.pop_front();
                chk("bus_we", {31'b0, bif.busWe}, {31'b0, t.we});
                chk("bus_addr", bif.busAddr, t.addr);
                chk("bus_wdata", bif.busWData, t.wdata);
                chk("bus_f3", {29'b0, bif.busFunc3}, {29'b0, t.f3});
            end else begin
                chk("bus_idle", {bif.busAddr[30:0] | bif.busWData[30:0],
                                 bif.busWe}, 0);
                chk("bus_idle_f3", {29'b0, bif.busFunc3}, 0);
            end
            if (bif.m0_done || bif.m1_done) begin
                id = bif.m1_done ? 1 : 0;
                if (dq.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    t = dq.pop_front();
                    chk("done_cycle", cyc, t.cyc + 2);
                    chk("done_id", id, t.id);
                    chk("done_rdata", bif.rdata, t.rd);
                end
            end
        end
    end

    initial begin
        int          k;
        int          g0;
        int          exp_ord [4];
        logic [31:0] saved;
`ifdef BUS_ARB_LOCK_EN
        exp_ord = '{1, 1, 1, 0};
`else
        exp_ord = '{1, 0, 1, 0};
`endif
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101;
            ref_mem[i] = 32'(i) * 32'h0101_0101;
        end
        mem[8]     = 32'h1234_5678;
        ref_mem[8] = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            pend[i]    = 1;
            granted[i] = 0;
            c_we[i]    = 1;
            c_addr[i]  = 32'(8 + i * 4);
            c_wdata[i] = 32'hFFFF_FFFF;
            c_f3[i]    = 3'b010;
            c_lock[i]  = 0;
        end
        c_we[0] = 0;
        c_we[1] = 0;
        drive();

        // Reset state with both masters requesting
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", {30'b0, bif.m0_gnt, bif.m1_gnt}, 0);
        chk("rst_done", {30'b0, bif.m0_done, bif.m1_done}, 0);
        chk("rst_rdata", bif.rdata, 0);
        chk("rst_bus", bif.busAddr | bif.busWData | 32'(bif.busWe), 0);

        // Tie right after reset: m0 first, then m1
        @(negedge clk);
        release_rst();
        drain();

        // Write then read back, then read-hold across a write
        issue(0, 1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0);
        issue(0, 0, 32'h10, 32'h0, 3'b010, 0);
        drain();
        chk("rd_back", bif.rdata, 32'hDEAD_BEEF);
        issue(1, 0, 32'h20, 32'h0, 3'b010, 0);
        issue(0, 1, 32'h24, 32'hCAFE_F00D, 3'b000, 0);
        drain();
        chk("rd_hold", bif.rdata, 32'h1234_5678);

        // Randomized traffic
        rnd = 1;
        repeat (400) step();
        rnd = 0;
        drain();

        // Reset during ACCESS of an m1 write
        saved = ref_mem[12];
        issue(1, 1, 32'h30, 32'hA5A5_A5A5, 3'b010, 0);
        step();
        step();
        #1;
        chk("pre_rst_we", {31'b0, bif.busWe}, 1);
        rst = 1'b0;
        model_reset();
        ref_mem[12] = saved;
        #1;
        chk("rst_we_drop", {31'b0, bif.busWe}, 0);
        @(negedge clk);
        #1;
        chk("rst_no_done", {30'b0, bif.m0_done, bif.m1_done}, 0);
        chk("rst_no_commit", mem[12], saved);
        chk("rst_rdata2", bif.rdata, 0);
        for (int i = 0; i < 2; i++) begin
            pend[i]   = 1;
            c_we[i]   = 0;
            c_addr[i] = 32'(i * 4);
            c_f3[i]   = 3'b010;
            c_lock[i] = 0;
        end
        drive();
        @(negedge clk);
        obs_q.delete();
        release_rst();
        drain();
        chk("tie_after_rst", 32'(obs_q.size() > 0 ? obs_q[0] : 9), 0);

        // Lock behaviour: m1 locked, both requesting continuously
        obs_q.delete();
        issue(1, 0, 32'h4, 32'h0, 3'b010, 1);
        step();
        refill = 1;
        g0 = gcount;
        k  = 0;
        while (gcount < g0 + 3 && k < 200) begin
            step();
            k++;
        end
        refill = 0;
        drain();
        chk("lock_cnt", 32'(obs_q.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            chk("lock_order", 32'(obs_q.size() > i ? obs_q[i] : 9), 32'(exp_ord[i]));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(gq.size() + aq.size() + dq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
